// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the round-robin search helper for rr_mux_arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scans ptr+1, ptr+2, ... ptr+8; the 3-bit add wraps 7->0, so ptr=7 starts at 0
    // and the final offset revisits ptr itself.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = ptr + SEL_W'(off);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux8.sv
// 8:1 single-bit mux channel: y = din[sel].
module mux8
    import arb_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [N_REQ-1:0] din,
    output logic             y
);

    assign y = din[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded hold time sequencing an 8:1 mux channel.
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       y
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q;
    logic [7:0] grant_q;
    logic [2:0] sel_q;
    logic [2:0] ptr_q;
    logic [3:0] hold_q;

    logic [7:0] others;
    pick_t      pick_next;
    pick_t      pick_rot;
    logic       y_mux;

    always_comb begin
        // grant_q is one-hot on sel_q while granted, so this masks out the current owner
        others    = req & ~grant_q;
        pick_next = rr_pick(req, ptr_q);
        pick_rot  = rr_pick(others, sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '1;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_next.found) begin
                        state_q <= GRANT;
                        grant_q <= 8'b1 << pick_next.idx;
                        sel_q   <= pick_next.idx;
                        ptr_q   <= pick_next.idx;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!req[sel_q]) begin
                        if (pick_next.found) begin
                            grant_q <= 8'b1 << pick_next.idx;
                            sel_q   <= pick_next.idx;
                            ptr_q   <= pick_next.idx;
                            hold_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (others != '0 && hold_q == HOLD_LAST) begin
                        grant_q <= 8'b1 << pick_rot.idx;
                        sel_q   <= pick_rot.idx;
                        ptr_q   <= pick_rot.idx;
                        hold_q  <= '0;
                    end else if (hold_q != HOLD_LAST) begin
                        // covers both the sole-requester saturation and the plain increment
                        hold_q <= hold_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mux8 u_mux8 (
        .sel (sel_q),
        .din (din),
        .y   (y_mux)
    );

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = (state_q == GRANT);
    assign y     = valid & y_mux;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a behavioural model pushes expected outputs per edge.
module tb_rr_mux_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] din = '0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic ey;

    // model state
    logic       m_v    = 1'b0;
    int         m_sel  = 0;
    int         m_ptr  = 7;
    int         m_hold = 0;

    rr_mux_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic rs);
        int w;
        logic [7:0] oth;
        if (rs) begin
            m_v = 1'b0; m_sel = 0; m_ptr = 7; m_hold = 0;
        end else if (!m_v) begin
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_v = 1'b1; m_sel = w; m_ptr = w; m_hold = 0;
            end
        end else begin
            oth = r;
            oth[m_sel] = 1'b0;
            if (!r[m_sel]) begin
                w = search(r, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_ptr = w; m_hold = 0;
                end else begin
                    m_v = 1'b0;
                end
            end else if (oth != 0 && m_hold == MAXH - 1) begin
                w = search(oth, m_sel);
                m_sel = w; m_ptr = w; m_hold = 0;
            end else if (oth == 0) begin
                if (m_hold < MAXH - 1) m_hold++;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        exp_t x;
        model_edge(req, rst);
        x.v = m_v;
        x.s = 3'(m_sel);
        x.g = m_v ? (8'b1 << m_sel) : 8'h00;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        din = 8'hFF;
        rst = 1'b1;
        tick();
        e = exp_q.pop_front();
        total++;
        if (grant !== 8'h00 || sel !== 3'd0 || valid !== 1'b0 || y !== 1'b0) begin
            bad++;
            $display("FAIL reset: grant=%h sel=%0d valid=%b y=%b want 00/0/0/0", grant, sel, valid, y);
        end
        rst = 1'b0;
        tick();
        e = exp_q.pop_front();
        total++;
        if (grant !== e.g || sel !== e.s || valid !== e.v) begin
            bad++;
            $display("FAIL reset_idle: grant=%h sel=%0d valid=%b want %h/%0d/%b", grant, sel, valid, e.g, e.s, e.v);
        end
        req = 8'h04;
        tick();
        e = exp_q.pop_front();
        total++;
        if (grant !== 8'h04 || sel !== 3'd2 || valid !== 1'b1 || e.g !== 8'h04) begin
            bad++;
            $display("FAIL first_grant: grant=%h sel=%0d valid=%b want 04/2/1", grant, sel, valid);
        end
        din = 8'h04;
        #1;
        total++;
        if (y !== 1'b1) begin
            bad++;
            $display("FAIL y_high: y=%b want 1", y);
        end
        din = 8'h00;
        #1;
        total++;
        if (y !== 1'b0) begin
            bad++;
            $display("FAIL y_low: y=%b want 0", y);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 8'hFF;
        for (int i = 0; i <= 32; i++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e.g || sel !== 3'((i / 4) % 8) || valid !== 1'b1 || !$onehot(grant)) begin
                bad++;
                $display("FAIL rotation[%0d]: grant=%h sel=%0d valid=%b want sel=%0d model grant=%h", i, grant, sel, valid, (i / 4) % 8, e.g);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rq [3];
        int         ws [3];
        rq = '{8'h08, 8'h28, 8'h20};
        ws = '{3, 3, 5};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req = rq[i];
            tick();
            e = exp_q.pop_front();
            total++;
            if (sel !== 3'(ws[i]) || valid !== 1'b1 || grant !== e.g) begin
                bad++;
                $display("FAIL back_to_back[%0d]: sel=%0d valid=%b grant=%h want sel=%0d valid=1 grant=%h", i, sel, valid, grant, ws[i], e.g);
            end
        end
    endtask

    task automatic test_wrap();
        int want;
        do_reset();
        req = 8'h80;
        tick();
        req = 8'h81;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            want = (i < 4) ? 7 : (i < 8) ? 0 : 7;
            if (i > 0 || exp_q.size() > 0) e = exp_q.pop_front();
            total++;
            if (sel !== 3'(want) || valid !== 1'b1 || grant !== e.g) begin
                bad++;
                $display("FAIL wrap[%0d]: sel=%0d grant=%h want sel=%0d grant=%h", i, sel, grant, want, e.g);
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        req = 8'h40;
        for (int i = 0; i < 21; i++) begin
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== 8'h40 || sel !== 3'd6 || valid !== 1'b1 || e.g !== 8'h40) begin
                bad++;
                $display("FAIL sole[%0d]: grant=%h sel=%0d want 40/6", i, grant, sel);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        din = 8'hFF;
        req = 8'h10;
        tick(); tick();
        exp_q.delete();
        rst = 1'b1;
        tick();
        e = exp_q.pop_front();
        total++;
        if (grant !== 8'h00 || valid !== 1'b0 || y !== 1'b0 || sel !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: grant=%h valid=%b y=%b sel=%0d want 00/0/0/0", grant, valid, y, sel);
        end
        rst = 1'b0;
        tick();
        e = exp_q.pop_front();
        total++;
        if (grant !== 8'h10 || sel !== 3'd4 || valid !== 1'b1 || y !== 1'b1) begin
            bad++;
            $display("FAIL regrant: grant=%h sel=%0d valid=%b y=%b want 10/4/1/1", grant, sel, valid, y);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            req = (i % 3 == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            din = 8'($urandom);
            tick();
            e = exp_q.pop_front();
            ey = e.v ? din[e.s] : 1'b0;
            total++;
            if (grant !== e.g || sel !== e.s || valid !== e.v || y !== ey) begin
                bad++;
                $display("FAIL random[%0d]: grant=%h sel=%0d valid=%b y=%b want %h/%0d/%b/%b", i, grant, sel, valid, y, e.g, e.s, e.v, ey);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_back_to_back();
        test_wrap();
        test_sole();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
